keypad_emulator: RTL
====================

Name: keypad_emulator

Overview:
- Responder side of the 4x4 matrix keypad interface: accepts an ASCII key code over a valid/ready handshake and emulates a physical key press on the row lines.
- Answers the column drive of the matrix scanner for a programmable hold time, then releases the key.
- Used for hardware loopback of the UART keyboard path (UART RX byte -> emulator -> scanner -> UART TX) and as a synthesizable bench model.

Parameters:
- HOLD_CYCLES, 33554432, cycles the key stays pressed; default is two full 4-column scans of the scanner (4 x 2^22 each).
- RELEASE_CYCLES, 16777216, minimum released gap after a press before the next code is accepted.
- CNT_W, 26, counter width; must hold max(HOLD_CYCLES, RELEASE_CYCLES)-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-low: sampled on posedge clk, asserted when 0.
- key_ascii  in  8  ASCII code of the key to press.
- key_valid  in  1  key_ascii is valid.
- key_ready  out  1  emulator can accept a code.
- col  in  4  column drive from the scanner; active-low; any pattern is legal.
- row  out  4  row lines to the scanner; active-low; 4'b1111 means no key.
- busy  out  1  press or release in progress.
- err  out  1  one-cycle pulse when an unmapped code is accepted.

Behaviour:
- Key map (col index c, row index r). Column c is active when col[c]=0; row r is driven by row[r]=0.
  - c0: r0 '0' 0x30, r1 '8' 0x38, r2 '5' 0x35, r3 '2' 0x32.
  - c1: r0 'E', r1 '7', r2 '4', r3 '1'.
  - c2: r0 'D', r1 'C', r2 'B', r3 'A'.
  - c3: r0 'F', r1 '9', r2 '6', r3 '3'.
  - Letters accepted in upper case (0x41-0x46) and lower case (0x61-0x66), since the scanner emits 0x62 for B and 0x64 for D.
- FSM states: IDLE, PRESS, RELEASE. Single down-counter cnt[CNT_W-1:0].
- Reset (rst=0 at posedge):
  - state=IDLE, cnt=0, latched c/r=0.
  - row=4'b1111, err=0, busy=0.
  - key_ready=1 from the first cycle after reset.
- Handshake: key_ready = (state==IDLE), decoded from the state register. Transfer occurs on posedge when key_valid & key_ready. key_valid is ignored outside IDLE; no buffering.
- IDLE, on transfer:
  - Mapped code: latch c, r; cnt<=HOLD_CYCLES-1; state<=PRESS.
  - Unmapped code: err=1 for exactly the next cycle; stay in IDLE. Back-to-back bad codes give back-to-back err pulses.
- PRESS: pressed=1. If cnt==0: cnt<=RELEASE_CYCLES-1 and state<=RELEASE; else cnt<=cnt-1. Total press length is exactly HOLD_CYCLES cycles.
- RELEASE: pressed=0. If cnt==0: state<=IDLE; else cnt<=cnt-1. Length is exactly RELEASE_CYCLES cycles.
- busy = (state != IDLE).
- Row response is registered, latency 1 cycle from col:
  - row[i] <= ~(pressed && i==r && col[c]==0).
  - All other row bits are 1.
  - With col=4'b0000 (scanner in reset), the pressed row still reads low. This matches a physical switch.
- pressed is state==PRESS. row releases (4'b1111) on the cycle after the state leaves PRESS.
- Reset mid-press: row returns to 4'b1111 the cycle after the reset edge; the latched key is discarded.
- HOLD_CYCLES or RELEASE_CYCLES equal to 1 is legal (single-cycle state). 0 is illegal.

Test Plan:
- (HOLD_CYCLES=8, RELEASE_CYCLES=4 for all.) Reset held 3 cycles -> row=1111, busy=0, err=0, key_ready=1 after release.
- Send 0x35 ('5'), col held 1110 -> from cycle after transfer +1, row=1011 for 8 cycles, then 1111.
  - key_ready=0 for 12 cycles, then 1.
  - Same test with col=1101 -> row stays 1111 throughout.
- Send 0x62 then (after ready) 0x42: both press c2 r2 -> row=1011 only while col[2]=0.
- Rotate col 1110->1101->1011->0111 each cycle during a '3' press -> row=0111 exactly one cycle after col=0111, else 1111.
- Send 0x47 ('G') -> err=1 for one cycle, busy stays 0, key_ready stays 1. key_valid held high during PRESS of '1' -> no second transfer until IDLE.
- Assert rst mid-PRESS of '9' with col=1011... use col=0111 -> row=1111 next cycle, state IDLE, key_ready=1 after reset.

Source files
------------

// File: rtl/keypad_emulator_if.sv
// Key handshake and matrix lines between a key source / scanner and the
// keypad emulator. The slave side is the emulator.
interface keypad_emulator_if;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       err;

    modport master (
        output key_ascii, key_valid, col,
        input  key_ready, row, busy, err
    );

    modport slave (
        input  key_ascii, key_valid, col,
        output key_ready, row, busy, err
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: takes an ASCII key code over valid/ready and
// answers the scanner's column drive on the row lines for a fixed hold time,
// then keeps the key released for a minimum gap before taking the next code.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no key pressed, key_ready high, waiting for a code
// ST_PRESS   | latched key held down for HOLD_CYCLES cycles
// ST_RELEASE | key released, enforced gap of RELEASE_CYCLES cycles
module keypad_emulator #(
    parameter int HOLD_CYCLES    = 33554432,
    parameter int RELEASE_CYCLES = 16777216,
    parameter int CNT_W          = 26
) (
    input  logic              clk,
    input  logic              rst,
    keypad_emulator_if.slave  kif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_c;
    logic [1:0]       r_r;
    logic [1:0]       w_c_nxt;
    logic [1:0]       w_r_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [3:0]       r_row;
    logic             w_ready;
    logic             w_xfer;
    logic             w_pressed;
    logic             w_map_ok;
    logic [1:0]       w_map_c;
    logic [1:0]       w_map_r;

    assign w_ready   = (r_state == ST_IDLE);
    assign w_xfer    = kif.key_valid & w_ready;
    assign w_pressed = (r_state == ST_PRESS);

    // ASCII to (column, row) lookup; letters map in both cases.
    always_comb begin
        w_map_ok = 1'b1;
        w_map_c  = 2'd0;
        w_map_r  = 2'd0;
        case (kif.key_ascii)
            8'h30:        begin w_map_c = 2'd0; w_map_r = 2'd0; end
            8'h38:        begin w_map_c = 2'd0; w_map_r = 2'd1; end
            8'h35:        begin w_map_c = 2'd0; w_map_r = 2'd2; end
            8'h32:        begin w_map_c = 2'd0; w_map_r = 2'd3; end
            8'h45, 8'h65: begin w_map_c = 2'd1; w_map_r = 2'd0; end
            8'h37:        begin w_map_c = 2'd1; w_map_r = 2'd1; end
            8'h34:        begin w_map_c = 2'd1; w_map_r = 2'd2; end
            8'h31:        begin w_map_c = 2'd1; w_map_r = 2'd3; end
            8'h44, 8'h64: begin w_map_c = 2'd2; w_map_r = 2'd0; end
            8'h43, 8'h63: begin w_map_c = 2'd2; w_map_r = 2'd1; end
            8'h42, 8'h62: begin w_map_c = 2'd2; w_map_r = 2'd2; end
            8'h41, 8'h61: begin w_map_c = 2'd2; w_map_r = 2'd3; end
            8'h46, 8'h66: begin w_map_c = 2'd3; w_map_r = 2'd0; end
            8'h39:        begin w_map_c = 2'd3; w_map_r = 2'd1; end
            8'h36:        begin w_map_c = 2'd3; w_map_r = 2'd2; end
            8'h33:        begin w_map_c = 2'd3; w_map_r = 2'd3; end
            default:      w_map_ok = 1'b0;
        endcase
    end

    // Next-state, hold/release timer and key latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_c_nxt     = r_c;
        w_r_nxt     = r_r;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_map_ok) begin
                        w_c_nxt     = w_map_c;
                        w_r_nxt     = w_map_r;
                        w_cnt_nxt   = HOLD_LD;
                        w_state_nxt = ST_PRESS;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_PRESS: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = RELEASE_LD;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, timer, latched key and error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_c     <= 2'd0;
            r_r     <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_c     <= w_c_nxt;
            r_r     <= w_r_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Registered row response: the latched row is pulled low while its column is driven.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row <= 4'b1111;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_row[i] <= ~(w_pressed && (r_r == 2'(i)) && !kif.col[r_c]);
            end
        end
    end

    assign kif.key_ready = w_ready;
    assign kif.busy      = ~w_ready;
    assign kif.err       = r_err;
    assign kif.row       = r_row;

endmodule
